td4_prog_mem: RTL and testbench
===============================

TD4_PROG_MEM -- requirements
Module: td4_prog_mem

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: load_en  input  1  1 = program-load mode, 0 = run mode.
REQ-004 SHALL have port: wr_valid  input  1  write-nibble strobe, level-sampled, one nibble accepted per cycle while high.
REQ-005 SHALL have port: din  input  4  nibble to write; high nibble (opcode) first, then low nibble (immediate).
REQ-006 SHALL have port: step_mode  input  1  1 = single-step, 0 = free-run.
REQ-007 SHALL have port: step_btn  input  1  asynchronous step request, level.
REQ-008 SHALL have port: pc  input  4  instruction address from CPU core.
REQ-009 SHALL have port: opcode  output  4  mem[pc][7:4].
REQ-010 SHALL have port: immediate  output  4  mem[pc][3:0].
REQ-011 SHALL have port: exec_mode  output  1  CPU execute enable for the current cycle.
REQ-012 SHALL have port: load_addr  output  4  next word address to be written.
REQ-013 SHALL have port: load_full  output  1  all 16 words written since entering LOAD.
REQ-014 SHALL have parameter: DEPTH, default 16, number of 8-bit words (fixed at 16; other values unsupported).

Function
REQ-015 SHALL hold a 16 x 8-bit storage array, written only in state LOAD.
REQ-016 SHALL implement FSM states RUN, LOAD_HI, LOAD_LO, FULL.
REQ-017 SHALL move from RUN to LOAD_HI on a cycle with load_en=1, clearing load_addr to 0 and load_full to 0.
REQ-018 SHALL, in LOAD_HI with wr_valid=1, latch din into a holding register and go to LOAD_LO; memory unchanged.
REQ-019 SHALL, in LOAD_LO with wr_valid=1, write {hold, din} to mem[load_addr] at that edge; if load_addr=15 go to FULL and set load_full=1, else increment load_addr and go to LOAD_HI.
REQ-020 SHALL ignore wr_valid in FULL and RUN; load_addr holds 15 in FULL (no wrap).
REQ-021 SHALL go from any LOAD_HI/LOAD_LO/FULL state to RUN on a cycle with load_en=0; a pending high nibble is discarded, memory unchanged, words not written keep prior contents.
REQ-022 SHALL drive opcode/immediate combinationally from mem[pc] in every state (zero-latency read, same-cycle as pc).
REQ-023 SHALL pass step_btn through a 2-flop synchronizer followed by a rising-edge detector producing a one-cycle step_pulse.
REQ-024 SHALL drive exec_mode = (state==RUN) & (step_mode ? step_pulse : 1); exec_mode=0 in all LOAD states.
REQ-025 SHALL produce exactly one exec_mode cycle per step_btn rising edge in single-step, independent of button hold time; re-arm requires step_btn low for >=1 synchronized sample.
REQ-026 SHALL discard step edges detected while not in RUN (no queued steps).
REQ-027 SHALL, when step_mode changes mid-run, take effect on the next cycle with no extra exec_mode pulse.

Reset
REQ-028 SHALL on rst_n=0 immediately set: state RUN, load_addr 0, load_full 0, hold 0, synchronizer and edge-detector flops 0, all memory words 8'h00.
REQ-029 SHALL, with rst_n low, drive exec_mode=0, opcode=0, immediate=0.
REQ-030 SHALL abandon any in-progress load on reset assertion mid-load; all words return to 8'h00.
REQ-031 SHALL on rst_n release resume in RUN (memory all zeros, i.e. ADD A,0 at every address) unless load_en=1.

Verification
REQ-032 Load: load_en=1, nibbles C,3,0,1,F,1 with wr_valid -> mem[0]=C3, mem[1]=01, mem[2]=F1, load_addr=3, load_full=0, exec_mode=0 throughout.
REQ-033 Full: 32 valid nibbles then 2 extra -> load_full=1 after 32nd, load_addr=15, mem[15]=last pair, extra nibbles ignored.
REQ-034 Partial abort: load_en falls after a lone high nibble A at addr 4 -> mem[4] unchanged, state RUN, exec_mode=1 next cycle (step_mode=0).
REQ-035 Step: step_mode=1, step_btn high for 10 cycles, low 3, high 2 -> exactly two exec_mode pulses, each 1 cycle, ~2-3 cycles after each rise.
REQ-036 Read: after load, pc swept 0..15 -> {opcode,immediate} equals mem[pc] same cycle.
REQ-037 Reset mid-load: rst_n low after 5 words -> all words 00, load_addr 0, load_full 0, state RUN after release with load_en=0.

Source files
------------

// File: rtl/td4_prog_mem.sv
// TD4 program memory: 16 x 8-bit store loaded one nibble at a time,
// zero-latency read port for the CPU core, and the run/single-step gate
// that produces the CPU execute enable.
//
// Load handshake: wr_valid is a level strobe. One nibble is taken on every
// rising clk edge where wr_valid=1 and the FSM is in LOAD_HI or LOAD_LO.
// There is no ready output: the loader is always ready in those two states,
// and wr_valid is ignored in RUN and FULL.
module td4_prog_mem #(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_en,
   input  logic       wr_valid,
   input  logic [3:0] din,
   input  logic       step_mode,
   input  logic       step_btn,
   input  logic [3:0] pc,
   output logic [3:0] opcode,
   output logic [3:0] immediate,
   output logic       exec_mode,
   output logic [3:0] load_addr,
   output logic       load_full,
   output logic [1:0] state_dbg_o
);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_LOAD_HI = 2'd1;
   localparam logic [1:0] ST_LOAD_LO = 2'd2;
   localparam logic [1:0] ST_FULL    = 2'd3;

   logic [1:0] state_q, state_d;
   logic [3:0] addr_q, addr_d;
   logic       full_q, full_d;
   logic [3:0] hold_q, hold_d;
   logic       mem_we;
   logic [7:0] mem_q [DEPTH];

   logic       sync1_q, sync2_q, prev_q;
   logic       step_pulse;

   // Load FSM next-state: nibble pairing, address advance, exit to RUN.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      full_d  = full_q;
      hold_d  = hold_q;
      mem_we  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (load_en) begin
               state_d = ST_LOAD_HI;
               addr_d  = 4'd0;
               full_d  = 1'b0;
            end
         end
         ST_LOAD_HI: begin
            if (!load_en) begin
               state_d = ST_RUN;
            end else if (wr_valid) begin
               hold_d  = din;
               state_d = ST_LOAD_LO;
            end
         end
         ST_LOAD_LO: begin
            if (!load_en) begin
               // A pending high nibble is simply dropped.
               state_d = ST_RUN;
            end else if (wr_valid) begin
               mem_we = 1'b1;
               if (addr_q == 4'd15) begin
                  state_d = ST_FULL;
                  full_d  = 1'b1;
               end else begin
                  addr_d  = addr_q + 4'd1;
                  state_d = ST_LOAD_HI;
               end
            end
         end
         default: begin
            // FULL: address parks at 15, further nibbles ignored.
            if (!load_en) begin
               state_d = ST_RUN;
            end
         end
      endcase
   end

   // Load FSM registers with asynchronous reset back to RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         addr_q  <= 4'd0;
         full_q  <= 1'b0;
         hold_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         full_q  <= full_d;
         hold_q  <= hold_d;
      end
   end

   // Storage array; reset clears every word so an unloaded program is ADD A,0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (mem_we) begin
         mem_q[addr_q] <= {hold_q, din};
      end
   end

   // Step button synchronizer and rising-edge history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= step_btn;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // One-cycle pulse per synchronized rise; it is never stored, so a rise
   // seen outside RUN is lost rather than queued.
   assign step_pulse = sync2_q & ~prev_q;

   // Execute enable is forced low while reset is held.
   assign exec_mode = rst_n & (state_q == ST_RUN) & (step_mode ? step_pulse : 1'b1);

   assign opcode      = mem_q[pc][7:4];
   assign immediate   = mem_q[pc][3:0];
   assign load_addr   = addr_q;
   assign load_full   = full_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_td4_prog_mem.sv
// Directed bench for td4_prog_mem: a per-cycle vector table for the basic
// load/abort/read flow, plus hand-written sequences for full load, read
// sweep, single-step, step-during-load and reset in the middle of a load.
module tb_td4_prog_mem;

   logic       clk;
   logic       rst_n;
   logic       load_en;
   logic       wr_valid;
   logic [3:0] din;
   logic       step_mode;
   logic       step_btn;
   logic [3:0] pc;
   logic [3:0] opcode;
   logic [3:0] immediate;
   logic       exec_mode;
   logic [3:0] load_addr;
   logic       load_full;
   logic [1:0] state_dbg;

   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_HI   = 2'd1;
   localparam logic [1:0] S_LO   = 2'd2;
   localparam logic [1:0] S_FULL = 2'd3;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       le;
      logic       wv;
      logic [3:0] din;
      logic [3:0] pc;
      logic       sm;
      logic       ex;
      logic [3:0] la;
      logic       lf;
      logic [1:0] st;
      logic [7:0] rd;
   } vec_t;

   vec_t vt [18];

   td4_prog_mem dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_en     (load_en),
      .wr_valid    (wr_valid),
      .din         (din),
      .step_mode   (step_mode),
      .step_btn    (step_btn),
      .pc          (pc),
      .opcode      (opcode),
      .immediate   (immediate),
      .exec_mode   (exec_mode),
      .load_addr   (load_addr),
      .load_full   (load_full),
      .state_dbg_o (state_dbg)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic le, input logic wv, input logic [3:0] d);
      load_en  = le;
      wr_valid = wv;
      din      = d;
   endtask

   initial begin
      int pulses;
      int p0;
      int p1;
      logic [3:0] kk;

      rst_n     = 1'b0;
      load_en   = 1'b0;
      wr_valid  = 1'b0;
      din       = 4'h0;
      step_mode = 1'b0;
      step_btn  = 1'b0;
      pc        = 4'h0;

      // Reset state (step_mode=0 would enable exec if reset did not gate it)
      #3;
      chk("rst_exec", {31'd0, exec_mode}, 32'd0);
      chk("rst_rd", {24'd0, opcode, immediate}, 32'h00);
      chk("rst_addr", {28'd0, load_addr}, 32'd0);
      chk("rst_full", {31'd0, load_full}, 32'd0);
      chk("rst_state", {30'd0, state_dbg}, {30'd0, S_RUN});
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #2;

      // Vector table: inputs for one cycle, outputs expected after that edge.
      //          le wv din    pc    sm  ex la    lf st    rd
      vt[0]  = '{1, 0, 4'h0, 4'h0, 0, 0, 4'd0, 0, S_HI,  8'h00};
      vt[1]  = '{1, 1, 4'hC, 4'h0, 0, 0, 4'd0, 0, S_LO,  8'h00};
      vt[2]  = '{1, 1, 4'h3, 4'h0, 0, 0, 4'd1, 0, S_HI,  8'hC3};
      vt[3]  = '{1, 1, 4'h0, 4'h1, 0, 0, 4'd1, 0, S_LO,  8'h00};
      vt[4]  = '{1, 0, 4'h5, 4'h1, 0, 0, 4'd1, 0, S_LO,  8'h00};
      vt[5]  = '{1, 1, 4'h1, 4'h1, 0, 0, 4'd2, 0, S_HI,  8'h01};
      vt[6]  = '{1, 1, 4'hF, 4'h2, 0, 0, 4'd2, 0, S_LO,  8'h00};
      vt[7]  = '{1, 1, 4'h1, 4'h2, 0, 0, 4'd3, 0, S_HI,  8'hF1};
      vt[8]  = '{1, 0, 4'h0, 4'h0, 0, 0, 4'd3, 0, S_HI,  8'hC3};
      vt[9]  = '{1, 1, 4'h7, 4'h3, 0, 0, 4'd3, 0, S_LO,  8'h00};
      vt[10] = '{1, 1, 4'h8, 4'h3, 0, 0, 4'd4, 0, S_HI,  8'h78};
      vt[11] = '{1, 1, 4'hA, 4'h4, 0, 0, 4'd4, 0, S_LO,  8'h00};
      vt[12] = '{0, 0, 4'h0, 4'h4, 0, 1, 4'd4, 0, S_RUN, 8'h00};
      vt[13] = '{0, 1, 4'h9, 4'h4, 0, 1, 4'd4, 0, S_RUN, 8'h00};
      vt[14] = '{1, 0, 4'h0, 4'h0, 0, 0, 4'd0, 0, S_HI,  8'hC3};
      vt[15] = '{0, 0, 4'h0, 4'h1, 0, 1, 4'd0, 0, S_RUN, 8'h01};
      vt[16] = '{0, 0, 4'h0, 4'h2, 1, 0, 4'd0, 0, S_RUN, 8'hF1};
      vt[17] = '{0, 0, 4'h0, 4'h2, 0, 1, 4'd0, 0, S_RUN, 8'hF1};

      for (int i = 0; i < 18; i++) begin
         drive(vt[i].le, vt[i].wv, vt[i].din);
         pc        = vt[i].pc;
         step_mode = vt[i].sm;
         step();
         chk($sformatf("v%0d_exec", i), {31'd0, exec_mode}, {31'd0, vt[i].ex});
         chk($sformatf("v%0d_addr", i), {28'd0, load_addr}, {28'd0, vt[i].la});
         chk($sformatf("v%0d_full", i), {31'd0, load_full}, {31'd0, vt[i].lf});
         chk($sformatf("v%0d_state", i), {30'd0, state_dbg}, {30'd0, vt[i].st});
         chk($sformatf("v%0d_rd", i), {24'd0, opcode, immediate}, {24'd0, vt[i].rd});
      end

      // Full load: 32 nibbles, word k = {k, ~k}, then two extra nibbles.
      drive(1'b1, 1'b0, 4'h0);
      step();
      chk("full_enter", {30'd0, state_dbg}, {30'd0, S_HI});
      for (int k = 0; k < 16; k++) begin
         kk = k[3:0];
         drive(1'b1, 1'b1, kk);
         step();
         chk($sformatf("full_hi%0d", k), {30'd0, state_dbg}, {30'd0, S_LO});
         drive(1'b1, 1'b1, ~kk);
         step();
         chk($sformatf("full_flag%0d", k), {31'd0, load_full}, (k == 15) ? 32'd1 : 32'd0);
         chk($sformatf("full_addr%0d", k), {28'd0, load_addr}, (k == 15) ? 32'd15 : k + 1);
         chk($sformatf("full_exec%0d", k), {31'd0, exec_mode}, 32'd0);
      end
      chk("full_state", {30'd0, state_dbg}, {30'd0, S_FULL});
      drive(1'b1, 1'b1, 4'h5);
      step();
      drive(1'b1, 1'b1, 4'h6);
      step();
      pc = 4'hF;
      #1;
      chk("extra_state", {30'd0, state_dbg}, {30'd0, S_FULL});
      chk("extra_addr", {28'd0, load_addr}, 32'd15);
      chk("extra_full", {31'd0, load_full}, 32'd1);
      chk("extra_mem15", {24'd0, opcode, immediate}, 32'hF0);

      // Leave load, then sweep pc with no clock edge between changes.
      drive(1'b0, 1'b0, 4'h0);
      step();
      chk("exit_state", {30'd0, state_dbg}, {30'd0, S_RUN});
      chk("exit_exec", {31'd0, exec_mode}, 32'd1);
      for (int k = 0; k < 16; k++) begin
         kk = k[3:0];
         pc = kk;
         #1;
         chk($sformatf("sweep%0d", k), {24'd0, opcode, immediate}, {24'd0, kk, ~kk});
      end

      // Single-step: high 10, low 3, high 2, then low.
      step_mode = 1'b1;
      step();
      pulses = 0;
      p0 = -1;
      p1 = -1;
      for (int c = 0; c < 22; c++) begin
         step_btn = (c < 10) || (c == 13) || (c == 14);
         step();
         if (exec_mode) begin
            pulses++;
            if (p0 < 0) p0 = c;
            else if (p1 < 0) p1 = c;
         end
      end
      chk("step_count", pulses, 32'd2);
      chk("step_pos0", p0, 32'd1);
      chk("step_pos1", p1, 32'd14);

      // A step rise while loading must not fire later in RUN.
      drive(1'b1, 1'b0, 4'h0);
      step();
      step_btn = 1'b1;
      for (int c = 0; c < 4; c++) step();
      step_btn = 1'b0;
      drive(1'b0, 1'b0, 4'h0);
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (exec_mode) pulses++;
      end
      chk("step_in_load", pulses, 32'd0);
      chk("step_in_load_state", {30'd0, state_dbg}, {30'd0, S_RUN});

      // Reset in the middle of a load after 5 words and a lone high nibble.
      step_mode = 1'b0;
      drive(1'b1, 1'b0, 4'h0);
      step();
      for (int k = 0; k < 11; k++) begin
         drive(1'b1, 1'b1, 4'h9);
         step();
      end
      chk("pre_rst_addr", {28'd0, load_addr}, 32'd5);
      chk("pre_rst_state", {30'd0, state_dbg}, {30'd0, S_LO});
      #2;
      rst_n = 1'b0;
      pc = 4'h0;
      #1;
      chk("mid_rst_state", {30'd0, state_dbg}, {30'd0, S_RUN});
      chk("mid_rst_addr", {28'd0, load_addr}, 32'd0);
      chk("mid_rst_full", {31'd0, load_full}, 32'd0);
      chk("mid_rst_rd0", {24'd0, opcode, immediate}, 32'h00);
      drive(1'b0, 1'b0, 4'h0);
      step();
      chk("mid_rst_exec", {31'd0, exec_mode}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_rst_state", {30'd0, state_dbg}, {30'd0, S_RUN});
      chk("post_rst_exec", {31'd0, exec_mode}, 32'd1);
      for (int k = 0; k < 16; k++) begin
         kk = k[3:0];
         pc = kk;
         #1;
         chk($sformatf("post_rst_mem%0d", k), {24'd0, opcode, immediate}, 32'h00);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
